// File: rtl/ace_save_pkg.sv
// Shared types and constants for the Jupiter Ace snapshot saver.
// rle_len gives the encoded size of one (byte, length) run.
package ace_save_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_WAIT  = 3'd2,
        ST_SCAN  = 3'd3,
        ST_EMIT  = 3'd4,
        ST_TAIL  = 3'd5,
        ST_FIN   = 3'd6
    } state_e;

    localparam logic [7:0] ESC_BYTE = 8'hED;
    localparam logic [7:0] END_MARK = 8'h00;

    function automatic logic [7:0] rle_len(input logic [7:0] b, input logic [7:0] n);
        logic [7:0] len;
        if ((b == ESC_BYTE) || (n >= 8'd5)) begin
            len = 8'd3;
        end else begin
            len = n;
        end
        return len;
    endfunction

endpackage

// File: rtl/ace_rle_emitter.sv
// Turns one (byte, length) run or the end marker into ED-RLE bytes,
// pushed through a single-entry output register at up to one byte per clock.
module ace_rle_emitter
    import ace_save_pkg::*;
#(
    parameter logic [7:0] ESC = ESC_BYTE
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       req_valid,
    input  logic       req_tail,
    input  logic [7:0] req_byte,
    input  logic [7:0] req_len,
    output logic       req_ready,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic       out_valid,
    output logic       idle
);

    logic       active_r;
    logic       tail_r;
    logic [7:0] byte_r;
    logic [7:0] len_r;
    logic [7:0] idx_r;
    logic [7:0] out_data_r;
    logic       out_valid_r;
    logic [7:0] last_idx_s;
    logic       load_ok_s;

    function automatic logic [7:0] enc_byte(input logic [7:0] b, input logic [7:0] n,
                                            input logic [7:0] idx, input logic tail);
        logic [7:0] r;
        if (tail) begin
            r = (idx == 8'd0) ? ESC : END_MARK;
        end else if ((b == ESC) || (n >= 8'd5)) begin
            case (idx)
                8'd0:    r = ESC;
                8'd1:    r = n;
                default: r = b;
            endcase
        end else begin
            r = b;
        end
        return r;
    endfunction

    // Index of the final byte of the group being encoded.
    always_comb begin
        last_idx_s = 8'd0;
        if (tail_r) begin
            last_idx_s = 8'd1;
        end else if ((byte_r == ESC) || (len_r >= 8'd5)) begin
            last_idx_s = 8'd2;
        end else begin
            last_idx_s = len_r - 8'd1;
        end
    end

    assign load_ok_s = !out_valid_r || out_ready;

    // Group sequencing and the output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_r    <= 1'b0;
            tail_r      <= 1'b0;
            byte_r      <= 8'd0;
            len_r       <= 8'd0;
            idx_r       <= 8'd0;
            out_data_r  <= 8'd0;
            out_valid_r <= 1'b0;
        end else if (clr) begin
            active_r    <= 1'b0;
            idx_r       <= 8'd0;
            out_valid_r <= 1'b0;
        end else if (active_r && load_ok_s) begin
            out_data_r  <= enc_byte(byte_r, len_r, idx_r, tail_r);
            out_valid_r <= 1'b1;
            idx_r       <= idx_r + 8'd1;
            if (idx_r == last_idx_s) begin
                active_r <= 1'b0;
            end
        end else begin
            if (load_ok_s) begin
                out_valid_r <= 1'b0;
            end
            if (req_valid && !active_r) begin
                byte_r   <= req_byte;
                len_r    <= req_len;
                tail_r   <= req_tail;
                idx_r    <= 8'd0;
                active_r <= 1'b1;
            end
        end
    end

    assign req_ready = !active_r;
    assign out_data  = out_data_r;
    assign out_valid = out_valid_r;
    assign idle      = !active_r && !out_valid_r;

endmodule

// File: rtl/ace_snapshot_saver.sv
// Reads the Ace RAM window one byte at a time, groups equal bytes into runs
// and hands them to the emitter, finishing with the ED 00 end marker.
module ace_snapshot_saver
    import ace_save_pkg::*;
#(
    parameter logic [15:0] START_ADDR = 16'h2000,
    parameter logic [15:0] END_ADDR   = 16'hFFFF,
    parameter logic [7:0]  ESC        = ESC_BYTE,
    parameter int          MAX_RUN    = 255,
    parameter int          RD_LAT     = 2
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        start,
    input  logic        abort,
    output logic        busy,
    output logic        done,
    output logic [15:0] mem_addr,
    output logic        mem_rd,
    input  logic [7:0]  mem_din,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [24:0] out_count
);

    localparam logic [16:0] END_EXT   = {1'b0, END_ADDR};
    localparam logic [7:0]  MAX_LEN   = 8'(MAX_RUN);
    localparam logic [1:0]  WAIT_LAST = 2'((RD_LAT >= 2) ? (RD_LAT - 2) : 0);

    state_e      state_r, state_nx;
    logic [16:0] addr_cnt_r;
    logic [1:0]  wait_cnt_r;
    logic [7:0]  run_byte_r, run_len_r, req_byte_r, req_len_r;
    logic        mem_rd_r, busy_r, done_r;
    logic [24:0] out_count_r;
    logic        reads_done_s, run_break_s;
    logic [7:0]  new_len_s;
    logic        req_valid_s, req_tail_s, req_ready_s, em_idle_s;

    // The 17-bit counter lets the window end at 16'hFFFF without wrapping.
    assign reads_done_s = addr_cnt_r > END_EXT;
    assign run_break_s  = (run_len_r != 8'd0) &&
                          !((mem_din == run_byte_r) && (run_len_r < MAX_LEN));
    assign new_len_s    = run_len_r + 8'd1;
    assign req_valid_s  = (state_r == ST_EMIT) || (state_r == ST_TAIL);
    assign req_tail_s   = (state_r == ST_TAIL);

    // State register.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx;
        end
    end

    // Next-state decode; abort wins over everything including start.
    always_comb begin
        state_nx = state_r;
        if (abort) begin
            state_nx = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE:  state_nx = start ? ST_FETCH : ST_IDLE;
                ST_FETCH: state_nx = (RD_LAT == 1) ? ST_SCAN : ST_WAIT;
                ST_WAIT:  state_nx = (wait_cnt_r == WAIT_LAST) ? ST_SCAN : ST_WAIT;
                ST_SCAN:  state_nx = (run_break_s || reads_done_s) ? ST_EMIT : ST_FETCH;
                ST_EMIT: begin
                    if (!req_ready_s) begin
                        state_nx = ST_EMIT;
                    end else if (!reads_done_s) begin
                        state_nx = ST_FETCH;
                    end else if (run_len_r != 8'd0) begin
                        state_nx = ST_EMIT;
                    end else begin
                        state_nx = ST_TAIL;
                    end
                end
                ST_TAIL:  state_nx = req_ready_s ? ST_FIN : ST_TAIL;
                ST_FIN:   state_nx = em_idle_s ? ST_IDLE : ST_FIN;
                default:  state_nx = ST_IDLE;
            endcase
        end
    end

    // Fetch address, run accumulation and status outputs.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            addr_cnt_r <= 17'd0;
            wait_cnt_r <= 2'd0;
            run_byte_r <= 8'd0;
            run_len_r  <= 8'd0;
            req_byte_r <= 8'd0;
            req_len_r  <= 8'd0;
            mem_rd_r   <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else if (abort) begin
            run_len_r <= 8'd0;
            mem_rd_r  <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            mem_rd_r <= (state_nx == ST_FETCH);
            done_r   <= (state_r == ST_FIN) && em_idle_s;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        addr_cnt_r <= {1'b0, START_ADDR};
                        run_len_r  <= 8'd0;
                        busy_r     <= 1'b1;
                    end
                end
                ST_FETCH: begin
                    addr_cnt_r <= addr_cnt_r + 17'd1;
                    wait_cnt_r <= 2'd0;
                end
                ST_WAIT: wait_cnt_r <= wait_cnt_r + 2'd1;
                ST_SCAN: begin
                    if (run_break_s) begin
                        req_byte_r <= run_byte_r;
                        req_len_r  <= run_len_r;
                        run_byte_r <= mem_din;
                        run_len_r  <= 8'd1;
                    end else if (reads_done_s) begin
                        req_byte_r <= mem_din;
                        req_len_r  <= new_len_s;
                        run_len_r  <= 8'd0;
                    end else begin
                        run_byte_r <= mem_din;
                        run_len_r  <= new_len_s;
                    end
                end
                ST_EMIT: begin
                    // After the last read a leftover run is queued as a second group.
                    if (req_ready_s && reads_done_s && (run_len_r != 8'd0)) begin
                        req_byte_r <= run_byte_r;
                        req_len_r  <= run_len_r;
                        run_len_r  <= 8'd0;
                    end
                end
                ST_FIN: begin
                    if (em_idle_s) begin
                        busy_r <= 1'b0;
                    end
                end
                default: busy_r <= busy_r;
            endcase
        end
    end

    // Accepted-byte counter, held across abort and cleared by a new save.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            out_count_r <= 25'd0;
        end else if ((state_r == ST_IDLE) && start && !abort) begin
            out_count_r <= 25'd0;
        end else if (out_valid && out_ready) begin
            out_count_r <= out_count_r + 25'd1;
        end
    end

    ace_rle_emitter #(
        .ESC(ESC)
    ) u_emitter (
        .clk       (clk_sys),
        .rst_n     (reset_n),
        .clr       (abort),
        .req_valid (req_valid_s),
        .req_tail  (req_tail_s),
        .req_byte  (req_byte_r),
        .req_len   (req_len_r),
        .req_ready (req_ready_s),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .idle      (em_idle_s)
    );

    assign mem_addr  = addr_cnt_r[15:0];
    assign mem_rd    = mem_rd_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign out_count = out_count_r;

endmodule

// File: tb/tb_ace_snapshot_saver.sv
// Directed bench: four saver instances (different windows / read latency)
// share one RAM model; the selected instance's stream is captured and checked.
module tb_ace_snapshot_saver;
    import ace_save_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [3:0]  start_v, abort_v, out_ready_v;
    logic [3:0]  busy_v, done_v, mem_rd_v, out_valid_v;
    logic [15:0] mem_addr_v [4];
    logic [7:0]  mem_din_v [4];
    logic [7:0]  out_data_v [4];
    logic [24:0] out_count_v [4];

    logic [7:0]  mem [0:65535];
    logic [7:0]  got [0:1023];
    int          got_n = 0;
    int          done_cnt = 0;
    int          stab_err = 0;
    logic        hold_v = 1'b0;
    logic [7:0]  hold_d = 8'd0;
    int          sel = 2;
    int          total = 0;
    int          bad = 0;
    logic [7:0]  exp_q [$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam logic [15:0] S_A = (g == 0) ? 16'hE000 : 16'h3000;
        localparam logic [15:0] E_A = (g == 0) ? 16'hFFFF : ((g == 1) ? 16'h3000 : 16'h3005);
        localparam int LAT = (g == 3) ? 4 : 2;
        logic [7:0] pipe [0:3];

        ace_snapshot_saver #(
            .START_ADDR(S_A), .END_ADDR(E_A), .ESC(8'hED), .MAX_RUN(255), .RD_LAT(LAT)
        ) u_dut (
            .clk_sys   (clk),
            .reset_n   (reset_n),
            .start     (start_v[g]),
            .abort     (abort_v[g]),
            .busy      (busy_v[g]),
            .done      (done_v[g]),
            .mem_addr  (mem_addr_v[g]),
            .mem_rd    (mem_rd_v[g]),
            .mem_din   (mem_din_v[g]),
            .out_data  (out_data_v[g]),
            .out_valid (out_valid_v[g]),
            .out_ready (out_ready_v[g]),
            .out_count (out_count_v[g])
        );

        // RAM with exactly LAT clocks of latency; junk data when no read was issued.
        always @(posedge clk) begin
            pipe[0] <= mem_rd_v[g] ? mem[mem_addr_v[g]] : 8'h5A;
            pipe[1] <= pipe[0];
            pipe[2] <= pipe[1];
            pipe[3] <= pipe[2];
        end
        assign mem_din_v[g] = pipe[LAT-1];
    end

    // Capture accepted bytes, done pulses and hold-stability of the selected instance.
    always @(posedge clk) begin
        if (out_valid_v[sel] && out_ready_v[sel]) begin
            got[got_n % 1024] <= out_data_v[sel];
            got_n <= got_n + 1;
        end
        if (done_v[sel]) begin
            done_cnt <= done_cnt + 1;
        end
        hold_v <= out_valid_v[sel] && !out_ready_v[sel];
        hold_d <= out_data_v[sel];
        if (hold_v && out_valid_v[sel] && (out_data_v[sel] !== hold_d)) begin
            stab_err <= stab_err + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load_s3(input logic [7:0] d5);
        mem[16'h3000] = 8'h12; mem[16'h3001] = 8'h12; mem[16'h3002] = 8'h12;
        mem[16'h3003] = 8'h12; mem[16'h3004] = d5;    mem[16'h3005] = 8'h34;
    endtask

    task automatic exp_s3();
        exp_q.delete();
        for (int i = 0; i < 4; i++) exp_q.push_back(8'h12);
        exp_q.push_back(8'hED); exp_q.push_back(8'h01); exp_q.push_back(8'hED);
        exp_q.push_back(8'h34); exp_q.push_back(8'hED); exp_q.push_back(8'h00);
    endtask

    task automatic run_save(input string name, input int g, input bit rnd,
                            input int restart_at, input int exp_cnt);
        int base, dbase, sbase;
        bit seen;
        base  = got_n;
        dbase = done_cnt;
        sbase = stab_err;
        seen  = 1'b0;
        sel   = g;
        out_ready_v[g] = 1'b1;
        start_v[g] = 1'b1;
        @(negedge clk);
        start_v[g] = 1'b0;
        chk({name, " busy_after_start"}, 32'(busy_v[g]), 32'd1);
        for (int c = 0; c < 60000 && !seen; c++) begin
            start_v[g] = (c == restart_at);
            if (rnd) out_ready_v[g] = 1'($urandom_range(0, 1));
            @(negedge clk);
            seen = (done_cnt != dbase);
        end
        start_v[g] = 1'b0;
        out_ready_v[g] = 1'b1;
        chk({name, " done_within_budget"}, 32'(seen), 32'd1);
        chk({name, " busy_cleared"}, 32'(busy_v[g]), 32'd0);
        chk({name, " byte_total"}, 32'(got_n - base), 32'(exp_cnt));
        chk({name, " out_count"}, 32'(out_count_v[g]), 32'(exp_cnt));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got_n - base)
                chk($sformatf("%s byte%0d", name, i), 32'(got[(base + i) % 1024]), 32'(exp_q[i]));
        end
        repeat (3) @(negedge clk);
        chk({name, " one_done_pulse"}, 32'(done_cnt - dbase), 32'd1);
        chk({name, " data_stable_when_held"}, 32'(stab_err - sbase), 32'd0);
    endtask

    initial begin
        int rd_cnt, exp_cnt, cnt_hold;
        reset_n     = 1'b0;
        start_v     = 4'h0;
        abort_v     = 4'h0;
        out_ready_v = 4'hF;
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        repeat (3) @(negedge clk);
        chk("reset busy", 32'(busy_v), 32'd0);
        chk("reset done", 32'(done_v), 32'd0);
        chk("reset mem_rd", 32'(mem_rd_v), 32'd0);
        chk("reset out_valid", 32'(out_valid_v), 32'd0);
        chk("reset out_count", 32'(out_count_v[2]), 32'd0);
        chk("reset mem_addr", 32'(mem_addr_v[0]), 32'd0);
        chk("reset out_data", 32'(out_data_v[2]), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // Zero-filled window up to 16'hFFFF: 8192 bytes = 32 x 255 + 32.
        exp_q.delete();
        exp_cnt = 0;
        for (int i = 0; i < 8192 / 255; i++) begin
            exp_q.push_back(8'hED); exp_q.push_back(8'hFF); exp_q.push_back(8'h00);
            exp_cnt += 32'(rle_len(8'h00, 8'd255));
        end
        exp_q.push_back(8'hED); exp_q.push_back(8'(8192 % 255)); exp_q.push_back(8'h00);
        exp_cnt += 32'(rle_len(8'h00, 8'(8192 % 255)));
        exp_q.push_back(8'hED); exp_q.push_back(8'h00);
        exp_cnt += 2;
        run_save("zeros", 0, 1'b0, -1, exp_cnt);

        // Single-byte window.
        mem[16'h3000] = 8'h41;
        exp_q.delete();
        exp_q.push_back(8'h41); exp_q.push_back(8'hED); exp_q.push_back(8'h00);
        run_save("single", 1, 1'b0, -1, 3);

        // Mixed data with an escape byte, then a five-long run.
        load_s3(8'hED);
        exp_s3();
        run_save("mixed", 2, 1'b0, -1, 10);
        load_s3(8'h12);
        exp_q.delete();
        exp_q.push_back(8'hED); exp_q.push_back(8'h05); exp_q.push_back(8'h12);
        exp_q.push_back(8'h34); exp_q.push_back(8'hED); exp_q.push_back(8'h00);
        run_save("run5", 2, 1'b0, -1, 6);

        // Random back-pressure.
        load_s3(8'hED);
        exp_s3();
        run_save("random_ready", 2, 1'b1, -1, 10);

        // Abort while the emitter is blocked by the consumer.
        sel = 2;
        out_ready_v[2] = 1'b0;
        start_v[2] = 1'b1;
        @(negedge clk);
        start_v[2] = 1'b0;
        repeat (25) @(negedge clk);
        out_ready_v[2] = 1'b1;
        @(negedge clk);
        out_ready_v[2] = 1'b0;
        rd_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            rd_cnt += 32'(mem_rd_v[2]);
            @(negedge clk);
        end
        chk("blocked no_reads", 32'(rd_cnt), 32'd0);
        chk("blocked out_valid", 32'(out_valid_v[2]), 32'd1);
        chk("blocked busy", 32'(busy_v[2]), 32'd1);
        cnt_hold = done_cnt;
        abort_v[2] = 1'b1;
        @(negedge clk);
        abort_v[2] = 1'b0;
        chk("abort out_valid", 32'(out_valid_v[2]), 32'd0);
        chk("abort busy", 32'(busy_v[2]), 32'd0);
        repeat (5) @(negedge clk);
        chk("abort no_done", 32'(done_cnt - cnt_hold), 32'd0);
        chk("abort count_held", 32'(out_count_v[2]), 32'd1);
        out_ready_v[2] = 1'b1;
        run_save("after_abort", 2, 1'b0, -1, 10);

        // Asynchronous reset while a read is being issued.
        start_v[2] = 1'b1;
        @(negedge clk);
        start_v[2] = 1'b0;
        for (int c = 0; c < 10 && !mem_rd_v[2]; c++) @(negedge clk);
        chk("fetch reached", 32'(mem_rd_v[2]), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("async mem_rd", 32'(mem_rd_v[2]), 32'd0);
        chk("async busy", 32'(busy_v[2]), 32'd0);
        chk("async mem_addr", 32'(mem_addr_v[2]), 32'd0);
        chk("async out_count", 32'(out_count_v[2]), 32'd0);
        chk("async out_valid", 32'(out_valid_v[2]), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        run_save("after_reset", 2, 1'b0, -1, 10);

        // start re-pulsed mid-save, and the four-clock read latency build.
        run_save("restart_ignored", 2, 1'b0, 4, 10);
        run_save("rd_lat4", 3, 1'b0, -1, 10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
